// File: rtl/ucaspian_metrics_pkg.sv
// Shared constants and address decode helper for the uCaspian metrics bank.
package ucaspian_metrics_pkg;

    localparam logic [7:0] METRIC_STATUS_ADDR = 8'd0;
    localparam logic [7:0] METRIC_BASE_ADDR   = 8'd1;

    // Counter indices used by the core
    localparam int MET_SPK = 0;
    localparam int MET_ACC = 1;
    localparam int MET_CLK = 2;

    typedef struct packed {
        logic       valid;  // address falls in a counter slot (k < 8)
        logic [2:0] k;      // counter index
        logic [1:0] b;      // byte index, 0 = MSB
    } cnt_sel_t;

    // Split a byte address into counter index and byte-within-counter.
    // The caller still has to reject k >= NUM_CNT.
    function automatic cnt_sel_t addr_to_cnt_byte(input logic [7:0] addr, input int bytes);
        cnt_sel_t sel;
        int off;
        int q;
        int r;
        off       = int'(addr) - int'(METRIC_BASE_ADDR);
        q         = off / bytes;
        r         = off % bytes;
        sel.valid = (addr >= METRIC_BASE_ADDR) && (q < 8);
        sel.k     = 3'(q);
        sel.b     = 2'(r);
        return sel;
    endfunction

endpackage

// File: rtl/ucaspian_metric_counter.sv
// One event counter with its read snapshot, sticky overflow flag and
// saturate/wrap handling.
module ucaspian_metric_counter
    import ucaspian_metrics_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic             snap_load,
    input  logic             rd_clear,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] snap,
    output logic             ovf
);

    logic [CNT_W-1:0] snap_src;
    logic [CNT_W-1:0] base;

    // Residue left after a read-clear; with a single-byte counter the
    // snapshot is taken in the same cycle, so subtract the live value.
    always_comb begin
        snap_src = snap_load ? cnt : snap;
        base     = cnt - snap_src;
    end

    // Counter, snapshot and flag update: reset > clear > read-clear > inc
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt  <= '0;
            snap <= '0;
            ovf  <= 1'b0;
        end else begin
            if (snap_load)
                snap <= cnt;
            if (rd_clear) begin
                ovf <= 1'b0;
                if (inc && (&base))
                    cnt <= SATURATE ? base : '0;
                else
                    cnt <= base + {{(CNT_W-1){1'b0}}, inc};
            end else if (inc) begin
                if (&cnt) begin
                    ovf <= 1'b1;
                    cnt <= SATURATE ? cnt : '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ucaspian_metrics.sv
// Metrics counter bank: address decode, one-shot request handshake and
// registered byte readout over NUM_CNT counters.
module ucaspian_metrics
    import ucaspian_metrics_pkg::*;
#(
    parameter int NUM_CNT  = 3,
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [NUM_CNT-1:0] inc,
    input  logic [7:0]         metric_addr,
    input  logic               metric_read,
    output logic [7:0]         metric_value,
    output logic               metric_send
);

    localparam int BYTES = CNT_W / 8;

    cnt_sel_t sel;
    logic     busy;
    logic     send_reg;
    logic     accept;
    logic [7:0] rdata;

    // Byte view of every counter: [k][j] with j = 0 the least significant byte
    logic [NUM_CNT-1:0][BYTES-1:0][7:0] cnt_all;
    logic [NUM_CNT-1:0][BYTES-1:0][7:0] snap_all;
    logic [NUM_CNT-1:0] ovf;
    logic [NUM_CNT-1:0] hit;
    logic [NUM_CNT-1:0] snap_load;
    logic [NUM_CNT-1:0] rd_clear;

    assign sel         = addr_to_cnt_byte(metric_addr, BYTES);
    assign accept      = metric_read && !busy;
    assign metric_send = send_reg && metric_read;

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        assign hit[i]       = sel.valid && (sel.k == 3'(i));
        assign snap_load[i] = accept && hit[i] && (sel.b == 2'd0);
        assign rd_clear[i]  = accept && hit[i] && (sel.b == 2'(BYTES-1));

        ucaspian_metric_counter #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear),
            .inc       (inc[i]),
            .snap_load (snap_load[i]),
            .rd_clear  (rd_clear[i]),
            .cnt       (cnt_all[i]),
            .snap      (snap_all[i]),
            .ovf       (ovf[i])
        );
    end

    // Read mux: status byte, live MSB, or snapshot byte; anything else is 0
    always_comb begin
        rdata = '0;
        if (metric_addr == METRIC_STATUS_ADDR)
            rdata = 8'(ovf);
        for (int i = 0; i < NUM_CNT; i++)
            for (int j = 0; j < BYTES; j++)
                if (hit[i] && (sel.b == 2'(BYTES-1-j)))
                    rdata = (j == BYTES-1) ? cnt_all[i][j] : snap_all[i][j];
    end

    // One acceptance per metric_read assertion; busy drops when read falls
    always_ff @(posedge clk) begin
        if (reset) begin
            busy         <= 1'b0;
            send_reg     <= 1'b0;
            metric_value <= '0;
        end else if (!metric_read) begin
            busy     <= 1'b0;
            send_reg <= 1'b0;
        end else if (!busy) begin
            busy         <= 1'b1;
            send_reg     <= 1'b1;
            metric_value <= rdata;
        end
    end

endmodule

// File: tb/tb_ucaspian_metrics.sv
// Directed bench for ucaspian_metrics: default 32-bit bank plus two 8-bit
// banks (saturate and wrap) sharing the same stimulus.
module tb_ucaspian_metrics;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic [2:0] inc = '0;
    logic [7:0] metric_addr = '0;
    logic       metric_read = 1'b0;
    logic [7:0] value, value_s, value_w;
    logic       send, send_s, send_w;
    logic [7:0] v_s, v_w;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ucaspian_metrics dut (
        .clk(clk), .reset(reset), .clear(clear), .inc(inc),
        .metric_addr(metric_addr), .metric_read(metric_read),
        .metric_value(value), .metric_send(send)
    );

    ucaspian_metrics #(.CNT_W(8), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset(reset), .clear(clear), .inc(inc),
        .metric_addr(metric_addr), .metric_read(metric_read),
        .metric_value(value_s), .metric_send(send_s)
    );

    ucaspian_metrics #(.CNT_W(8), .SATURATE(1'b0)) dut_w (
        .clk(clk), .reset(reset), .clear(clear), .inc(inc),
        .metric_addr(metric_addr), .metric_read(metric_read),
        .metric_value(value_w), .metric_send(send_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Single read: request at a negedge, sample one cycle later, drop read
    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        metric_addr = a;
        metric_read = 1'b1;
        @(negedge clk);
        chk({tag, " send"}, 32'(send), 32'd1);
        chk(tag, 32'(value), 32'(exp));
        v_s = value_s;
        v_w = value_w;
        metric_read = 1'b0;
    endtask

    // n clock edges with inc[k] high
    task automatic pulse(input int k, input int n);
        @(negedge clk);
        inc = 3'(1 << k);
        repeat (n) @(negedge clk);
        inc = '0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset value", 32'(value), 32'h0);
        chk("reset send", 32'(send), 32'h0);
        reset = 1'b0;

        // byte ordering: 300 = 0x0000012C on counter 2
        pulse(2, 300);
        rd(8'd9,  8'h00, "cnt2 b0");
        rd(8'd10, 8'h00, "cnt2 b1");
        rd(8'd11, 8'h01, "cnt2 b2");
        rd(8'd12, 8'h2C, "cnt2 b3");
        rd(8'd0,  8'h00, "status none");

        // coherent read while counting: snapshot 6, residue 7
        pulse(0, 5);
        inc = 3'b001;
        rd(8'd1, 8'h00, "coh b0");
        rd(8'd2, 8'h00, "coh b1");
        rd(8'd3, 8'h00, "coh b2");
        rd(8'd4, 8'h06, "coh b3");
        inc = '0;
        rd(8'd1, 8'h00, "coh res b0");
        rd(8'd4, 8'h07, "coh res b3");

        // read-to-clear residue on counter 1
        pulse(1, 100);
        rd(8'd5, 8'h00, "res b0");
        pulse(1, 7);
        rd(8'd8, 8'h64, "res b3");
        rd(8'd5, 8'h00, "res2 b0");
        rd(8'd8, 8'h07, "res2 b3");
        // inc high on the clearing edge is kept
        pulse(1, 3);
        rd(8'd5, 8'h00, "resinc b0");
        inc = 3'b010;
        rd(8'd8, 8'h03, "resinc b3");
        inc = '0;
        rd(8'd5, 8'h00, "resinc2 b0");
        rd(8'd8, 8'h02, "resinc2 b3");

        // one response for a 6-cycle held read of the LSB
        pulse(0, 3);
        rd(8'd1, 8'h00, "hold b0");
        @(negedge clk);
        metric_addr = 8'd4;
        metric_read = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            #1;
            chk($sformatf("hold send c%0d", c), 32'(send), (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) chk($sformatf("hold value c%0d", c), 32'(value), 32'h3);
            @(negedge clk);
        end
        metric_read = 1'b0;
        #1;
        chk("hold send drop", 32'(send), 32'h0);
        rd(8'd200, 8'h00, "invalid 200");
        rd(8'd13,  8'h00, "invalid 13");
        rd(8'd1,   8'h00, "hold after b0");
        rd(8'd4,   8'h00, "hold after b3");

        // clear beats read-clear and increment in the same cycle
        pulse(1, 2);
        pulse(0, 5);
        rd(8'd1, 8'h00, "prio b0");
        @(negedge clk);
        metric_addr = 8'd4;
        metric_read = 1'b1;
        clear = 1'b1;
        inc = 3'b001;
        @(negedge clk);
        chk("prio value", 32'(value), 32'h5);
        clear = 1'b0;
        inc = '0;
        metric_read = 1'b0;
        rd(8'd1, 8'h00, "prio after b0");
        rd(8'd4, 8'h00, "prio after b3");
        rd(8'd5, 8'h00, "prio cnt1 b0");
        rd(8'd8, 8'h00, "prio cnt1 b3");

        // reset in the middle of a held read
        pulse(0, 4);
        rd(8'd1, 8'h00, "rst b0");
        @(negedge clk);
        metric_addr = 8'd4;
        metric_read = 1'b1;
        @(negedge clk);
        chk("rst send before", 32'(send), 32'h1);
        chk("rst value before", 32'(value), 32'h4);
        reset = 1'b1;
        @(negedge clk);
        chk("rst send", 32'(send), 32'h0);
        chk("rst value", 32'(value), 32'h0);
        reset = 1'b0;
        metric_read = 1'b0;
        rd(8'd1, 8'h00, "rst after b0");
        rd(8'd4, 8'h00, "rst after b3");

        // 8-bit banks: 300 increments saturate to FF or wrap to 2C
        pulse(0, 300);
        rd(8'd0, 8'h00, "ovf main status");
        chk("sat status", 32'(v_s), 32'h1);
        chk("wrap status", 32'(v_w), 32'h1);
        rd(8'd1, 8'h00, "ovf main b0");
        chk("sat value", 32'(v_s), 32'hFF);
        chk("wrap value", 32'(v_w), 32'h2C);
        rd(8'd0, 8'h00, "ovf main status2");
        chk("sat status cleared", 32'(v_s), 32'h0);
        chk("wrap status cleared", 32'(v_w), 32'h0);
        rd(8'd1, 8'h00, "ovf main b0 again");
        chk("sat value cleared", 32'(v_s), 32'h0);
        chk("wrap value cleared", 32'(v_w), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
